// File: rtl/uart_rx_top_pkg.sv
// uart_rx_top_pkg: receiver state encoding, default parameters and tick divisor helper
package uart_rx_top_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;
   localparam int DEF_NB_DATA      = 32;
   localparam int DEF_NB_STOP      = 16;
   localparam int DEF_BAUD_RATE    = 19200;
   localparam int DEF_CLK_FREQ     = 50_000_000;
   localparam int DEF_OVERSAMPLING = 16;
   function automatic int tick_div(input int clk_freq, input int baud_rate, input int oversampling);
      return clk_freq / (baud_rate * oversampling);
   endfunction
endpackage

// File: rtl/baudrate_generator.sv
// baudrate_generator: free-running divider producing a one-clk oversampling tick every DIV clks
module baudrate_generator import uart_rx_top_pkg::*; #(
   parameter int CLK_FREQ     = DEF_CLK_FREQ,
   parameter int BAUD_RATE    = DEF_BAUD_RATE,
   parameter int OVERSAMPLING = DEF_OVERSAMPLING
)(
   input  logic clk,
   input  logic i_rst_n,
   output logic o_tick
);
   localparam int DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLING);
   localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge i_rst_n)
      if (!i_rst_n) cnt <= '0;
      else          cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
   // gated by reset so the strobe is low while reset is held even when DIV is 1
   assign o_tick = i_rst_n && (cnt == LAST);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: tick-driven receiver FSM sampling mid-bit, LSB first, stop level ignored
module uart_rx import uart_rx_top_pkg::*; #(
   parameter int NB_DATA      = DEF_NB_DATA,
   parameter int NB_STOP      = DEF_NB_STOP,
   parameter int OVERSAMPLING = DEF_OVERSAMPLING
)(
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_tick,
   input  logic               i_data,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_rxdone
);
   localparam int SMAX = NB_STOP > OVERSAMPLING ? NB_STOP : OVERSAMPLING;
   localparam int SW   = SMAX > 1 ? $clog2(SMAX) : 1;
   localparam int NW   = NB_DATA > 1 ? $clog2(NB_DATA) : 1;
   localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLING / 2 - 1);
   localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLING - 1);
   localparam logic [SW-1:0] S_STOP = SW'(NB_STOP - 1);
   localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);
   state_t             state, state_nxt;
   logic [SW-1:0]      s, s_nxt;
   logic [NW-1:0]      n, n_nxt;
   logic [NB_DATA-1:0] shreg, sh_nxt;
   logic               done;
   always_ff @(posedge clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state    <= IDLE;
         s        <= '0;
         n        <= '0;
         shreg    <= '0;
         o_data   <= '0;
         o_rxdone <= 1'b0;
      end else begin
         state    <= state_nxt;
         s        <= s_nxt;
         n        <= n_nxt;
         shreg    <= sh_nxt;
         o_data   <= done ? shreg : o_data;
         o_rxdone <= done;
      end
   always_comb begin
      state_nxt = state;
      s_nxt     = s;
      n_nxt     = n;
      sh_nxt    = shreg;
      case (state)
         IDLE:
            if (!i_data) begin
               state_nxt = START;
               s_nxt     = '0;
            end
         START:
            if (i_tick) begin
               if (s == S_MID) begin
                  // a line that is high again at mid start bit was only a glitch
                  state_nxt = i_data ? IDLE : DATA;
                  s_nxt     = '0;
                  n_nxt     = '0;
               end else
                  s_nxt = s + SW'(1);
            end
         DATA:
            if (i_tick) begin
               if (s == S_BIT) begin
                  s_nxt  = '0;
                  sh_nxt = {i_data, shreg[NB_DATA-1:1]};
                  if (n == N_LAST) state_nxt = STOP;
                  else             n_nxt     = n + NW'(1);
               end else
                  s_nxt = s + SW'(1);
            end
         STOP:
            if (i_tick) begin
               if (s == S_STOP) begin
                  state_nxt = IDLE;
                  s_nxt     = '0;
               end else
                  s_nxt = s + SW'(1);
            end
         default: state_nxt = IDLE;
      endcase
   end
   always_comb done = (state == STOP) && i_tick && (s == S_STOP);
endmodule

// File: rtl/uart_rx_top.sv
// uart_rx_top: UART receiver with oversampling tick generator and 2-flop input synchronizer
module uart_rx_top import uart_rx_top_pkg::*; #(
   parameter int NB_DATA      = DEF_NB_DATA,
   parameter int NB_STOP      = DEF_NB_STOP,
   parameter int BAUD_RATE    = DEF_BAUD_RATE,
   parameter int CLK_FREQ     = DEF_CLK_FREQ,
   parameter int OVERSAMPLING = DEF_OVERSAMPLING
)(
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_data,
   output logic               o_tick,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_rxdone
);
   logic [1:0] sync;
   logic       rx;
   // resets to idle-high so reset release never looks like a start bit
   always_ff @(posedge clk or negedge i_rst_n)
      if (!i_rst_n) sync <= 2'b11;
      else          sync <= {sync[0], i_data};
   assign rx = sync[1];
   baudrate_generator #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD_RATE(BAUD_RATE),
      .OVERSAMPLING(OVERSAMPLING)
   ) u_baud (
      .clk(clk),
      .i_rst_n(i_rst_n),
      .o_tick(o_tick)
   );
   uart_rx #(
      .NB_DATA(NB_DATA),
      .NB_STOP(NB_STOP),
      .OVERSAMPLING(OVERSAMPLING)
   ) u_rx (
      .clk(clk),
      .i_rst_n(i_rst_n),
      .i_tick(o_tick),
      .i_data(rx),
      .o_data(o_data),
      .o_rxdone(o_rxdone)
   );
endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: default-parameter tick timing plus frame-level checks on a fast-baud instance
module tb_uart_rx_top;
   localparam int DIV_D  = 162;
   localparam int DIV_F  = 2;
   localparam int CLK_F  = 19200 * 16 * DIV_F;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        line = 1'b1;
   logic        line_d = 1'b1;
   logic        tick_d, done_d, tick_f, done_f;
   logic [31:0] data_d, data_f;
   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int wide = 0;
   int stray = 0;
   logic        prev_done = 1'b0;
   logic [31:0] prev_data = '0;
   always #5 clk = ~clk;
   uart_rx_top dut_d (
      .clk(clk), .i_rst_n(rst_n), .i_data(line_d),
      .o_tick(tick_d), .o_data(data_d), .o_rxdone(done_d)
   );
   uart_rx_top #(
      .NB_DATA(32), .NB_STOP(16), .BAUD_RATE(19200), .CLK_FREQ(CLK_F), .OVERSAMPLING(16)
   ) dut (
      .clk(clk), .i_rst_n(rst_n), .i_data(line),
      .o_tick(tick_f), .o_data(data_f), .o_rxdone(done_f)
   );
   // frame monitor: counts pulses, flags multi-cycle pulses and o_data changes outside a pulse
   always @(posedge clk) begin
      #2;
      if (done_f) done_cnt++;
      if (done_f && prev_done) wide++;
      if (rst_n && !done_f && data_f !== prev_data) stray++;
      prev_done = done_f;
      prev_data = data_f;
   end
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask
   task automatic ticks(input int n);
      repeat (n * DIV_F) @(negedge clk);
   endtask
   task automatic send(input logic [31:0] w, input bit stop_hi);
      line = 1'b0;
      ticks(16);
      for (int i = 0; i < 32; i++) begin
         line = w[i];
         ticks(16);
      end
      line = stop_hi;
      ticks(stop_hi ? 16 : 12);
      line = 1'b1;
   endtask
   task automatic glitch(input int len);
      line = 1'b0;
      ticks(len);
      line = 1'b1;
      ticks(12);
   endtask
   typedef struct {
      int          gap;
      int          glen;
      logic [31:0] word;
      bit          stop_hi;
      int          exp_done;
      logic [31:0] exp_data;
   } vec_t;
   vec_t tbl[8];
   initial begin
      int c, w, p, base, gap;
      logic [31:0] model, rw;
      bit sh;
      tbl[0] = '{10, 0, 32'h20010014, 1'b1, 1, 32'h20010014};
      tbl[1] = '{0,  4, 32'h0,        1'b1, 0, 32'h20010014};
      tbl[2] = '{10, 0, 32'hA5A5A5A5, 1'b1, 1, 32'hA5A5A5A5};
      tbl[3] = '{0,  0, 32'h5A5A5A5A, 1'b1, 1, 32'h5A5A5A5A};
      tbl[4] = '{10, 0, 32'hFFFFFFFF, 1'b0, 1, 32'hFFFFFFFF};
      tbl[5] = '{12, 1, 32'h0,        1'b1, 0, 32'hFFFFFFFF};
      tbl[6] = '{10, 0, 32'h00000000, 1'b1, 1, 32'h00000000};
      tbl[7] = '{0,  6, 32'h0,        1'b1, 0, 32'h00000000};
      repeat (3) @(negedge clk);
      check("rst_tick_d", tick_d, 0);
      check("rst_done_d", done_d, 0);
      check("rst_data_d", data_d, 0);
      check("rst_tick_f", tick_f, 0);
      check("rst_done_f", done_f, 0);
      check("rst_data_f", data_f, 0);
      rst_n = 1'b1;
      // first tick falls in the DIV-th clk after release, then every DIV clks, one clk wide
      c = 0;
      while (!tick_d && c < 1000) begin
         @(negedge clk);
         c++;
      end
      check("first_tick_cycle", c, DIV_D - 1);
      for (int k = 0; k < 2; k++) begin
         w = 0;
         while (tick_d && w < 10) begin
            @(negedge clk);
            w++;
         end
         check($sformatf("tick_width%0d", k), w, 1);
         p = w;
         while (!tick_d && p < 1000) begin
            @(negedge clk);
            p++;
         end
         check($sformatf("tick_period%0d", k), p, DIV_D);
      end
      for (int i = 0; i < 8; i++) begin
         ticks(tbl[i].gap);
         base = done_cnt;
         if (tbl[i].glen > 0) glitch(tbl[i].glen);
         else                 send(tbl[i].word, tbl[i].stop_hi);
         check($sformatf("vec%0d_pulses", i), done_cnt - base, tbl[i].exp_done);
         check($sformatf("vec%0d_data", i), data_f, tbl[i].exp_data);
      end
      // reference model: o_data is the last fully sent word; glitches deliver nothing
      model = 32'h0;
      for (int k = 0; k < 16; k++) begin
         gap = $urandom_range(12, 30);
         ticks(gap);
         base = done_cnt;
         if ($urandom_range(0, 3) == 0) begin
            glitch($urandom_range(1, 5));
            check($sformatf("rnd%0d_glitch_pulses", k), done_cnt - base, 0);
         end else begin
            rw = $urandom;
            sh = 1'($urandom_range(0, 1));
            send(rw, sh);
            model = rw;
            check($sformatf("rnd%0d_pulses", k), done_cnt - base, 1);
         end
         check($sformatf("rnd%0d_data", k), data_f, model);
      end
      ticks(12);
      base = done_cnt;
      rw = 32'hDEADBEEF;
      line = 1'b0;
      ticks(16);
      for (int i = 0; i < 10; i++) begin
         line = rw[i];
         ticks(16);
      end
      line = rw[10];
      ticks(8);
      rst_n = 1'b0;
      ticks(2);
      check("midrst_data", data_f, 0);
      check("midrst_done", done_f, 0);
      check("midrst_tick", tick_f, 0);
      line = 1'b1;
      ticks(4);
      rst_n = 1'b1;
      ticks(40 * 16);
      check("midrst_no_pulse", done_cnt - base, 0);
      check("midrst_data_held", data_f, 0);
      send(32'h00000001, 1'b1);
      check("postrst_pulses", done_cnt - base, 1);
      check("postrst_data", data_f, 32'h00000001);
      ticks(20);
      check("pulse_width_violations", wide, 0);
      check("odata_stray_changes", stray, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
